// File: rtl/score_player.sv
// Sequential score reader: walks every score address, latches each note/length
// pair after the read latency and holds the note for a length-scaled duration.
module score_player #(
  parameter int audio_len      = 6,
  parameter int TICKS_PER_UNIT = 12500000,
  parameter int GAP_TICKS      = 1250000,
  parameter int READ_LAT       = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [4:0]           note_in,
  input  logic [1:0]           length_in,
  output logic [audio_len-1:0] score_noteAdr,
  output logic [4:0]           play_note,
  output logic                 note_valid,
  output logic                 note_strobe,
  output logic                 busy,
  output logic                 done
);

  localparam int DUR_W = $clog2(8 * TICKS_PER_UNIT);
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [DUR_W-1:0] DUR0 = DUR_W'(TICKS_PER_UNIT - 1);
  localparam logic [DUR_W-1:0] DUR1 = DUR_W'(2 * TICKS_PER_UNIT - 1);
  localparam logic [DUR_W-1:0] DUR2 = DUR_W'(4 * TICKS_PER_UNIT - 1);
  localparam logic [DUR_W-1:0] DUR3 = DUR_W'(8 * TICKS_PER_UNIT - 1);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);
  localparam logic [audio_len-1:0] ADR_LAST = '1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [audio_len-1:0] adr_q;
  logic [LAT_W-1:0]     lat_q;
  logic [DUR_W-1:0]     dur_q;
  logic [GAP_W-1:0]     gap_q;
  logic [4:0]           note_q;
  logic                 first_q;
  logic [DUR_W-1:0]     dur_load;
  logic                 last_entry;

  always_comb begin
    dur_load = DUR0;
    case (length_in)
      2'd0: dur_load = DUR0;
      2'd1: dur_load = DUR1;
      2'd2: dur_load = DUR2;
      default: dur_load = DUR3;
    endcase
  end

  assign last_entry = (adr_q == ADR_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !stop) state_d = S_FETCH;
      S_FETCH: if (lat_q == LAT_LAST) state_d = S_PLAY;
      S_PLAY: begin
        if (dur_q == '0) begin
          if (GAP_TICKS > 0) state_d = S_GAP;
          else               state_d = last_entry ? S_DONE : S_FETCH;
        end
      end
      S_GAP:   if (gap_q == GAP_LAST) state_d = last_entry ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (stop && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      lat_q   <= '0;
      dur_q   <= '0;
      gap_q   <= '0;
      note_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (state_d == S_FETCH) begin
            adr_q <= '0;
            lat_q <= '0;
          end
        end
        S_FETCH: begin
          lat_q <= lat_q + LAT_W'(1);
          if (state_d == S_PLAY) begin
            note_q  <= note_in;
            dur_q   <= dur_load;
            first_q <= 1'b1;
          end
        end
        S_PLAY: begin
          dur_q   <= dur_q - DUR_W'(1);
          first_q <= 1'b0;
        end
        S_GAP:   gap_q <= gap_q + GAP_W'(1);
        default: ;
      endcase
      if (state_d == S_GAP && state_q != S_GAP) gap_q <= '0;
      // Next-entry step reaches FETCH from either PLAY or GAP.
      if (state_d == S_FETCH && (state_q == S_PLAY || state_q == S_GAP)) begin
        adr_q <= adr_q + audio_len'(1);
        lat_q <= '0;
      end
      if (state_d == S_IDLE) begin
        adr_q   <= '0;
        first_q <= 1'b0;
      end
    end
  end

  assign score_noteAdr = adr_q;
  assign play_note     = (state_q == S_PLAY) ? note_q : '0;
  assign note_valid    = (state_q == S_PLAY) && (note_q != '0);
  assign note_strobe   = (state_q == S_PLAY) && first_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_score_player.sv
// Scoreboard bench for score_player: stimulus queues expected strobe/done
// events, a negedge monitor pops and compares them and checks held notes.
module tb_score_player;

  localparam int AL  = 2;
  localparam int TPU = 4;
  localparam int RL  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start0 = 1'b0, stop0 = 1'b0, start1 = 1'b0, stop1 = 1'b0;
  logic [4:0] note_in0, note_in1, play0, play1;
  logic [1:0] len_in0, len_in1;
  logic [AL-1:0] adr0, adr1;
  logic nv0, nv1, stb0, stb1, busy0, busy1, done0, done1;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic [4:0] mem_note [4];
  logic [1:0] mem_len  [4];

  typedef struct {
    bit         is_done;
    logic [4:0] note;
    logic [1:0] len;
    int         adr;
    int         cyc;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  cur_note [2];
  int  left [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    note_in0 <= mem_note[adr0];
    len_in0  <= mem_len[adr0];
    note_in1 <= mem_note[adr1];
    len_in1  <= mem_len[adr1];
  end

  score_player #(.audio_len(AL), .TICKS_PER_UNIT(TPU), .GAP_TICKS(1), .READ_LAT(RL)) u_gap (
    .clk(clk), .reset_n(reset_n), .start(start0), .stop(stop0),
    .note_in(note_in0), .length_in(len_in0), .score_noteAdr(adr0),
    .play_note(play0), .note_valid(nv0), .note_strobe(stb0),
    .busy(busy0), .done(done0));

  score_player #(.audio_len(AL), .TICKS_PER_UNIT(TPU), .GAP_TICKS(0), .READ_LAT(RL)) u_nogap (
    .clk(clk), .reset_n(reset_n), .start(start1), .stop(stop1),
    .note_in(note_in1), .length_in(len_in1), .score_noteAdr(adr1),
    .play_note(play1), .note_valid(nv1), .note_strobe(stb1),
    .busy(busy1), .done(done1));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input ev_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Reference timing: each entry costs READ_LAT + (TPU << len) + gap cycles.
  task automatic push_pass(input int k, input int base, input int gap);
    ev_t e;
    int t = base;
    for (int i = 0; i < 4; i++) begin
      t += RL;
      e = '{is_done: 1'b0, note: mem_note[i], len: mem_len[i], adr: i, cyc: t};
      push(k, e);
      t += (TPU << mem_len[i]) + gap;
    end
    e = '{is_done: 1'b1, note: 5'd0, len: 2'd0, adr: 0, cyc: t};
    push(k, e);
  endtask

  task automatic mon(input int k, input logic stb, input logic dn, input logic [4:0] pn,
                     input logic nv, input logic bs, input int adr);
    ev_t e;
    int  qs;
    if (stb || dn) begin
      qs = (k == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        chk($sformatf("unexpected_event_%0d", k), 1, 0);
      end else begin
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("event_kind_%0d", k), int'(dn), int'(e.is_done));
        chk($sformatf("event_cycle_%0d", k), cyc, e.cyc);
        if (!e.is_done) begin
          chk($sformatf("strobe_adr_%0d", k), adr, e.adr);
          chk($sformatf("strobe_note_%0d", k), int'(pn), int'(e.note));
          cur_note[k] = int'(e.note);
          left[k] = TPU << e.len;
        end
      end
    end
    if (!bs) left[k] = 0;
    if (left[k] > 0) begin
      chk($sformatf("play_note_%0d", k), int'(pn), cur_note[k]);
      chk($sformatf("note_valid_%0d", k), int'(nv), int'(cur_note[k] != 0));
      left[k]--;
    end
  endtask

  always @(negedge clk) begin
    mon(0, stb0, done0, play0, nv0, busy0, int'(adr0));
    mon(1, stb1, done1, play1, nv1, busy1, int'(adr1));
  end

  task automatic pulse_start(input int k, output int base);
    @(negedge clk);
    if (k == 0) start0 = 1'b1;
    else        start1 = 1'b1;
    base = cyc + 1;
    push_pass(k, base, (k == 0) ? 1 : 0);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n = 0;
    logic bs;
    do begin
      @(negedge clk);
      n++;
      bs = (k == 0) ? busy0 : busy1;
    end while (bs && n < budget);
    chk($sformatf("idle_timeout_%0d", k), int'(bs), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int base;
    mem_note[0] = 5'd5;  mem_len[0] = 2'd0;
    mem_note[1] = 5'd9;  mem_len[1] = 2'd1;
    mem_note[2] = 5'd0;  mem_len[2] = 2'd2;
    mem_note[3] = 5'd17; mem_len[3] = 2'd3;
    left[0] = 0; left[1] = 0; cur_note[0] = 0; cur_note[1] = 0;

    // 1: reset then idle
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs_0", int'({adr0, play0, nv0, stb0, busy0, done0}), 0);
      chk("idle_outputs_1", int'({adr1, play1, nv1, stb1, busy1, done1}), 0);
    end

    // 2: full pass with gap
    pulse_start(0, base);
    chk("busy_after_start", int'(busy0), 1);
    wait_idle(0, 200);
    chk("queue_drained_pass", q0.size(), 0);

    // 3: stop during second note
    pulse_start(0, base);
    while (cyc != base + 12) @(negedge clk);
    stop0 = 1'b1;
    @(negedge clk);
    stop0 = 1'b0;
    q0.delete();
    chk("stop_play_note", int'(play0), 0);
    chk("stop_note_valid", int'(nv0), 0);
    chk("stop_busy", int'(busy0), 0);
    chk("stop_adr", int'(adr0), 0);
    repeat (100) @(negedge clk);

    // 4: start while busy is ignored; start with stop in IDLE stays idle
    pulse_start(0, base);
    while (cyc != base + 10) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(0, 200);
    chk("queue_drained_restart", q0.size(), 0);
    @(negedge clk);
    start0 = 1'b1;
    stop0  = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    stop0  = 1'b0;
    chk("start_stop_busy", int'(busy0), 0);
    repeat (10) @(negedge clk);
    chk("start_stop_busy_later", int'(busy0), 0);

    // 5: reset during first gap, then replay
    pulse_start(0, base);
    while (cyc != base + 6) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    q0.delete();
    chk("reset_mid_outputs", int'({adr0, play0, nv0, stb0, busy0, done0}), 0);
    repeat (3) @(negedge clk);
    pulse_start(0, base);
    wait_idle(0, 200);
    chk("queue_drained_replay", q0.size(), 0);

    // 6: no-gap instance
    pulse_start(1, base);
    wait_idle(1, 200);
    chk("queue_drained_nogap", q1.size(), 0);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
